// File: rtl/udp_tx_arbiter.sv
// rtl/udp_tx_arbiter.sv - packet-granular round-robin arbiter in front of the UDP transmit interface
module udp_tx_arbiter #(
  parameter int DATA_W      = 7680,
  parameter int TIMEOUT_CYC = 50000,
  parameter int MIN_GAP     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [15:0]       req0_length,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [15:0]       req1_length,
  output logic              req1_ready,
  output logic              udp_send_data_valid,
  input  logic              udp_send_data_ready,
  output logic [DATA_W-1:0] udp_send_data,
  output logic [15:0]       udp_send_data_length,
  output logic              grant_id,
  output logic              busy,
  output logic [15:0]       sent_cnt0,
  output logic [15:0]       sent_cnt1,
  output logic [15:0]       drop_cnt0,
  output logic [15:0]       drop_cnt1
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int GW = $clog2(MIN_GAP + 1);
  localparam logic [16:0] MAX_LEN  = 17'(DATA_W / 8);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] G_LAST = GW'(MIN_GAP - 1);

  logic [1:0]        state;
  logic              last_grant;
  logic [TW-1:0]     tcnt;
  logic [GW-1:0]     gcnt;

  logic              pick;
  logic [15:0]       sel_len;
  logic [DATA_W-1:0] sel_data;
  logic              len_ok;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // On contention the requester that did not win last time goes next.
  always_comb begin
    pick     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    sel_len  = pick ? req1_length : req0_length;
    sel_data = pick ? req1_data : req0_data;
    len_ok   = (sel_len != 16'd0) && ({1'b0, sel_len} <= MAX_LEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= ST_IDLE;
      last_grant           <= 1'b1;
      tcnt                 <= '0;
      gcnt                 <= '0;
      req0_ready           <= 1'b0;
      req1_ready           <= 1'b0;
      udp_send_data_valid  <= 1'b0;
      udp_send_data        <= '0;
      udp_send_data_length <= 16'd0;
      grant_id             <= 1'b0;
      busy                 <= 1'b0;
      sent_cnt0            <= 16'd0;
      sent_cnt1            <= 16'd0;
      drop_cnt0            <= 16'd0;
      drop_cnt1            <= 16'd0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0_valid || req1_valid) begin
            udp_send_data        <= sel_data;
            udp_send_data_length <= sel_len;
            grant_id             <= pick;
            last_grant           <= pick;
            req0_ready           <= ~pick;
            req1_ready           <= pick;
            busy                 <= 1'b1;
            tcnt                 <= '0;
            gcnt                 <= '0;
            if (len_ok) begin
              udp_send_data_valid <= 1'b1;
              state               <= ST_SEND;
            end else begin
              // Unsendable length: captured and released, but counted as a drop.
              if (pick) drop_cnt1 <= sat_inc(drop_cnt1);
              else      drop_cnt0 <= sat_inc(drop_cnt0);
              state <= ST_GAP;
            end
          end
        end
        ST_SEND: begin
          if (udp_send_data_ready) begin
            if (grant_id) sent_cnt1 <= sat_inc(sent_cnt1);
            else          sent_cnt0 <= sat_inc(sent_cnt0);
            udp_send_data_valid <= 1'b0;
            state               <= ST_GAP;
          end else if (tcnt == T_LAST) begin
            if (grant_id) drop_cnt1 <= sat_inc(drop_cnt1);
            else          drop_cnt0 <= sat_inc(drop_cnt0);
            udp_send_data_valid <= 1'b0;
            state               <= ST_GAP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gcnt == G_LAST) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: begin
          udp_send_data_valid <= 1'b0;
          busy                <= 1'b0;
          state               <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb/tb_udp_tx_arbiter.sv - directed self-checking bench for udp_tx_arbiter
module tb_udp_tx_arbiter;
  localparam int DW = 7680;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [DW-1:0] req0_data, req1_data, udp_send_data;
  logic [15:0]   req0_length, req1_length, udp_send_data_length;
  logic          udp_send_data_valid, udp_send_data_ready, grant_id, busy;
  logic [15:0]   sent_cnt0, sent_cnt1, drop_cnt0, drop_cnt1;

  logic          s_req0_valid, s_req1_valid, s_req0_ready, s_req1_ready;
  logic [7:0]    s_req0_data, s_req1_data, s_udp_send_data;
  logic [15:0]   s_req0_length, s_req1_length, s_udp_send_data_length;
  logic          s_udp_send_data_valid, s_udp_send_data_ready, s_grant_id, s_busy;
  logic [15:0]   s_sent_cnt0, s_sent_cnt1, s_drop_cnt0, s_drop_cnt1;

  udp_tx_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(20), .MIN_GAP(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_length(req0_length), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_length(req1_length), .req1_ready(req1_ready),
    .udp_send_data_valid(udp_send_data_valid), .udp_send_data_ready(udp_send_data_ready),
    .udp_send_data(udp_send_data), .udp_send_data_length(udp_send_data_length),
    .grant_id(grant_id), .busy(busy),
    .sent_cnt0(sent_cnt0), .sent_cnt1(sent_cnt1), .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1)
  );

  udp_tx_arbiter #(.DATA_W(8), .TIMEOUT_CYC(2), .MIN_GAP(1)) dut_sat (
    .clk(clk), .rst(rst),
    .req0_valid(s_req0_valid), .req0_data(s_req0_data), .req0_length(s_req0_length), .req0_ready(s_req0_ready),
    .req1_valid(s_req1_valid), .req1_data(s_req1_data), .req1_length(s_req1_length), .req1_ready(s_req1_ready),
    .udp_send_data_valid(s_udp_send_data_valid), .udp_send_data_ready(s_udp_send_data_ready),
    .udp_send_data(s_udp_send_data), .udp_send_data_length(s_udp_send_data_length),
    .grant_id(s_grant_id), .busy(s_busy),
    .sent_cnt0(s_sent_cnt0), .sent_cnt1(s_sent_cnt1), .drop_cnt0(s_drop_cnt0), .drop_cnt1(s_drop_cnt1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_grant(input string tag);
    for (int i = 0; i < 12 && !(req0_ready || req1_ready); i++) tick();
    check(tag, 32'(req0_ready | req1_ready), 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && busy; i++) tick();
    check(tag, 32'(busy), 0);
  endtask

  logic [DW-1:0] d0, d1;
  int vcnt, bcnt, pulses, vseen, n;
  int g[4];
  int t[4];

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_length = 0; req1_length = 0;
    req0_data = '0; req1_data = '0; udp_send_data_ready = 0;
    s_req0_valid = 0; s_req1_valid = 0; s_req0_length = 0; s_req1_length = 0;
    s_req0_data = 8'h00; s_req1_data = 8'h00; s_udp_send_data_ready = 0;
    d0 = {(DW/32){32'hA5C3_0F01}};
    d1 = {(DW/32){32'h5A3C_F010}};
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_valid", 32'(udp_send_data_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_readies", 32'({req0_ready, req1_ready}), 0);
    check("rst_counters", 32'(sent_cnt0 | sent_cnt1 | drop_cnt0 | drop_cnt1), 0);

    // single maximum-length packet, UDP stack always ready
    req0_data = d0; req0_length = 16'd960; udp_send_data_ready = 1; req0_valid = 1;
    tick();
    check("single_ready0", 32'(req0_ready), 1);
    check("single_valid", 32'(udp_send_data_valid), 1);
    check("single_grant", 32'(grant_id), 0);
    check("single_data", 32'(udp_send_data == d0), 1);
    check("single_len", 32'(udp_send_data_length), 960);
    req0_valid = 0;
    vcnt = 1; bcnt = 1; pulses = 0;
    for (int i = 0; i < 50 && busy; i++) begin
      tick();
      if (req0_ready) pulses++;
      if (udp_send_data_valid) vcnt++;
      if (busy) bcnt++;
    end
    check("single_idle", 32'(busy), 0);
    check("single_extra_ready", pulses, 0);
    check("single_valid_cycles", vcnt, 1);
    check("single_busy_cycles", bcnt, 9);
    check("single_sent0", 32'(sent_cnt0), 1);
    check("single_data_held", 32'(udp_send_data == d0), 1);

    // contention with both requesters always pending
    do_reset();
    req0_data = d0; req0_length = 16'd100; req1_data = d1; req1_length = 16'd200;
    req0_valid = 1; req1_valid = 1; udp_send_data_ready = 1;
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      tick();
      if (req0_ready || req1_ready) begin
        g[n] = int'(req1_ready);
        t[n] = c;
        if (n == 1) check("cont_len1", 32'(udp_send_data_length), 200);
        if (n == 2) check("cont_data0", 32'(udp_send_data == d0), 1);
        n++;
      end
    end
    req0_valid = 0; req1_valid = 0;
    check("cont_grants", n, 4);
    check("cont_order", 32'({g[0][0], g[1][0], g[2][0], g[3][0]}), 32'b0101);
    check("cont_space01", t[1] - t[0], 10);
    check("cont_space12", t[2] - t[1], 10);
    check("cont_space23", t[3] - t[2], 10);
    wait_idle("cont_idle");
    check("cont_sent0", 32'(sent_cnt0), 2);
    check("cont_sent1", 32'(sent_cnt1), 2);

    // timeout on requester 1, then ready arriving on the last allowed cycle
    do_reset();
    udp_send_data_ready = 0; req1_data = d1; req1_length = 16'd64; req1_valid = 1;
    wait_grant("to_grant");
    req1_valid = 0;
    check("to_grant_id", 32'(grant_id), 1);
    vcnt = 1;
    for (int i = 0; i < 100 && udp_send_data_valid; i++) begin
      tick();
      if (udp_send_data_valid) vcnt++;
    end
    check("to_valid_cycles", vcnt, 20);
    check("to_drop1", 32'(drop_cnt1), 1);
    check("to_sent1", 32'(sent_cnt1), 0);
    wait_idle("to_idle");
    req1_valid = 1;
    wait_grant("to2_grant");
    req1_valid = 0;
    vcnt = 1;
    for (int i = 0; i < 100 && udp_send_data_valid; i++) begin
      if (vcnt == 20) udp_send_data_ready = 1;
      tick();
      if (udp_send_data_valid) vcnt++;
    end
    udp_send_data_ready = 0;
    check("to2_valid_cycles", vcnt, 20);
    check("to2_sent1", 32'(sent_cnt1), 1);
    check("to2_drop1", 32'(drop_cnt1), 1);
    wait_idle("to2_idle");

    // bad lengths: zero and one byte over the bus capacity
    udp_send_data_ready = 1;
    for (int k = 0; k < 2; k++) begin
      req0_length = (k == 0) ? 16'd0 : 16'd961;
      req0_valid = 1;
      wait_grant("bad_grant");
      req0_valid = 0;
      check("bad_ready0", 32'(req0_ready), 1);
      vseen = int'(udp_send_data_valid);
      bcnt = 1;
      for (int i = 0; i < 50 && busy; i++) begin
        tick();
        if (udp_send_data_valid) vseen++;
        if (busy) bcnt++;
      end
      check("bad_no_valid", vseen, 0);
      check("bad_gap_cycles", bcnt, 8);
    end
    check("bad_drop0", 32'(drop_cnt0), 2);
    check("bad_sent0", 32'(sent_cnt0), 0);

    // asynchronous reset while a packet is being offered
    udp_send_data_ready = 0; req1_length = 16'd10; req1_valid = 1;
    wait_grant("mid_grant");
    req1_valid = 0;
    tick();
    tick();
    tick();
    check("mid_pre_valid", 32'(udp_send_data_valid), 1);
    rst = 1'b1;
    #1;
    check("mid_valid", 32'(udp_send_data_valid), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_grant", 32'(grant_id), 0);
    check("mid_len", 32'(udp_send_data_length), 0);
    check("mid_data", 32'(udp_send_data == '0), 1);
    check("mid_counters", 32'(sent_cnt0 | sent_cnt1 | drop_cnt0 | drop_cnt1), 0);
    tick();
    rst = 1'b0;
    tick();
    udp_send_data_ready = 1; req0_valid = 1; req1_valid = 1; req0_length = 16'd100;
    wait_grant("post_grant");
    check("post_first_req0", 32'({req0_ready, req1_ready}), 32'b10);
    req0_valid = 0; req1_valid = 0;
    wait_idle("post_idle");
    check("post_sent0", 32'(sent_cnt0), 1);
    check("post_sent1", 32'(sent_cnt1), 0);

    // counter saturation on a small, fast instance using length-0 drops
    s_req1_valid = 1;
    n = 0;
    for (int c = 0; c < 140000 && n < 65537; c++) begin
      tick();
      if (s_req1_ready) begin
        n++;
        if (n == 65534) check("sat_fffe", 32'(s_drop_cnt1), 32'hFFFE);
      end
    end
    s_req1_valid = 0;
    check("sat_count", n, 65537);
    check("sat_drop1", 32'(s_drop_cnt1), 32'hFFFF);
    check("sat_drop0", 32'(s_drop_cnt0), 0);
    check("sat_sent", 32'(s_sent_cnt0 | s_sent_cnt1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
